// File: rtl/muladd_tester_pkg.sv
// muladd_tester_pkg
// Shared definitions for the MULADD IO-ring tester: the sequencer state
// encoding, the io_in/io_out pin positions used by the user design, and the
// reference arithmetic the tester compares each returned result against.
package muladd_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DUT_RST = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Pin positions on the user design's io_in bus
  localparam int RST_BIT = 0;
  localparam int EN_BIT  = 1;
  localparam int A_LSB   = 2;
  localparam int B_LSB   = 10;
  localparam int C_LSB   = 18;

  localparam int RES_W = 20;   // result width on io_out[19:0]
  localparam int W_W   = 23;   // operand word {c,b,a}
  localparam int IO_W  = 28;   // io ring width

  // Sign-extended 8x8 product plus zero-extended 7-bit addend, mod 2^20
  function automatic logic [RES_W-1:0] muladd_expected(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [6:0] c
  );
    logic signed [15:0] prod_s;
    logic [RES_W-1:0]   sum_s;
    prod_s = $signed(a) * $signed(b);
    sum_s  = {{4{prod_s[15]}}, prod_s} + {13'd0, c};
    return sum_s;
  endfunction

  // Error counter increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r_s;
    if (v == 16'hFFFF) begin
      r_s = v;
    end else begin
      r_s = v + 16'd1;
    end
    return r_s;
  endfunction

endpackage

// File: rtl/muladd_tester_opgen.sv
// muladd_tester_opgen
// Operand word generator for the MULADD tester. Produces the 23-bit word
// w = {c[6:0], b[7:0], a[7:0]} that is driven for the next vector.
//   Build option MULADD_TESTER_LFSR_EN:
//     defined   -> Fibonacci LFSR x^23 + x^18 + 1, loaded with SEED
//     undefined -> up-counter loaded with 0 (vector k is simply k)
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   load        restart the sequence (takes priority over step)
//   step        advance to the next word
//   w           current operand word
module muladd_tester_opgen
  import muladd_tester_pkg::*;
#(
  parameter logic [W_W-1:0] SEED = 23'h000001
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  output logic [W_W-1:0] w
);

`ifdef MULADD_TESTER_LFSR_EN
  localparam logic [W_W-1:0] LOAD_VAL = SEED;
`else
  localparam logic [W_W-1:0] LOAD_VAL = 23'd0;
`endif

  logic [W_W-1:0] w_r;
  logic [W_W-1:0] w_next_s;

  // Successor of the current word in the selected sequence
  always_comb begin
    w_next_s = w_r;
`ifdef MULADD_TESTER_LFSR_EN
    w_next_s = {w_r[W_W-2:0], w_r[22] ^ w_r[17]};
`else
    w_next_s = w_r + 23'd1;
`endif
  end

  // Generator register: load beats step, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_r <= LOAD_VAL;
    end else if (load) begin
      w_r <= LOAD_VAL;
    end else if (step) begin
      w_r <= w_next_s;
    end else begin
      w_r <= w_r;
    end
  end

  assign w = w_r;

endmodule

// File: rtl/muladd_io_tester.sv
// muladd_io_tester
// Stimulus/response engine for the 8x8+7 MULADD user design. Resets the
// design through its io_in pins, then for each vector drives {c,b,a},
// waits SAMPLE_DELAY cycles, samples io_out and compares against the
// reference arithmetic. Reports busy/done/pass, a saturating mismatch count
// and the first failing vector with the value it returned.
// Operand source selected by MULADD_TESTER_LFSR_EN (see muladd_tester_opgen).
// Ports:
//   clk, rst_n    shared clock / asynchronous active-low reset
//   start         one-cycle run request, honoured only in IDLE or DONE
//   dut_io_in     [0] DUT reset, [1] enable, [9:2] a, [17:10] b, [24:18] c
//   dut_io_out    [19:0] result, [27:20] must read zero
//   busy, done    run in progress / run finished (level)
//   pass          done with zero mismatches
//   err_count     mismatching checks, saturating
//   fail_vec      {c,b,a} of the first mismatch
//   fail_got      io_out[19:0] seen at the first mismatch
module muladd_io_tester
  import muladd_tester_pkg::*;
#(
  parameter int             N_VEC        = 256,
  parameter int             SAMPLE_DELAY = 2,
  parameter logic [W_W-1:0] SEED         = 23'h000001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IO_W-1:0]  dut_io_in,
  input  logic [IO_W-1:0]  dut_io_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [W_W-1:0]   fail_vec,
  output logic [RES_W-1:0] fail_got
);

  localparam logic [W_W-1:0]  LAST_IDX  = W_W'(N_VEC - 1);
  localparam logic [3:0]      WAIT_LAST = 4'(SAMPLE_DELAY - 2);
  localparam logic [IO_W-1:0] IO_RESET  = 28'h0000001; // DUT in reset, enable low
  localparam logic [IO_W-1:0] IO_DUTRST = 28'h0000003; // DUT in reset, enable high

  state_t           state_r, state_n;
  logic [3:0]       cnt_r, cnt_n;
  logic [W_W-1:0]   vec_idx_r, vec_idx_n;
  logic [IO_W-1:0]  io_r, io_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             pass_r, pass_n;
  logic [15:0]      err_r, err_n;
  logic [W_W-1:0]   fail_vec_r, fail_vec_n;
  logic [RES_W-1:0] fail_got_r, fail_got_n;
  logic             fail_seen_r, fail_seen_n;

  logic             load_s;
  logic             step_s;
  logic [W_W-1:0]   w_s;
  logic [RES_W-1:0] exp_s;
  logic             mismatch_s;

  muladd_tester_opgen #(.SEED(SEED)) u_opgen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .step  (step_s),
    .w     (w_s)
  );

  // Reference result and mismatch for the vector currently on the pins
  always_comb begin
    exp_s      = muladd_expected(io_r[A_LSB +: 8], io_r[B_LSB +: 8], io_r[C_LSB +: 7]);
    mismatch_s = (dut_io_out[RES_W-1:0] != exp_s) || (dut_io_out[IO_W-1:RES_W] != 8'd0);
  end

  // Sequencer next-state and next values of every registered output
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    vec_idx_n   = vec_idx_r;
    io_n        = io_r;
    busy_n      = busy_r;
    done_n      = done_r;
    pass_n      = pass_r;
    err_n       = err_r;
    fail_vec_n  = fail_vec_r;
    fail_got_n  = fail_got_r;
    fail_seen_n = fail_seen_r;
    load_s      = 1'b0;
    step_s      = 1'b0;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n     = ST_DUT_RST;
          cnt_n       = 4'd0;
          vec_idx_n   = 23'd0;
          io_n        = IO_DUTRST;
          busy_n      = 1'b1;
          done_n      = 1'b0;
          pass_n      = 1'b0;
          err_n       = 16'd0;
          fail_vec_n  = 23'd0;
          fail_got_n  = 20'd0;
          fail_seen_n = 1'b0;
          load_s      = 1'b1;
        end else begin
          state_n = state_r;
        end
      end

      ST_DUT_RST: begin
        // Second reset cycle: the held-in-reset design must read zero
        if (cnt_r == 4'd1) begin
          state_n = ST_DRIVE;
          cnt_n   = 4'd0;
          if (dut_io_out[RES_W-1:0] != 20'd0) begin
            err_n = sat_inc16(err_r);
          end else begin
            err_n = err_r;
          end
        end else begin
          cnt_n = cnt_r + 4'd1;
        end
      end

      ST_DRIVE: begin
        io_n                = 28'd0;
        io_n[RST_BIT]       = 1'b0;
        io_n[EN_BIT]        = 1'b1;
        io_n[A_LSB +: 8]    = w_s[7:0];
        io_n[B_LSB +: 8]    = w_s[15:8];
        io_n[C_LSB +: 7]    = w_s[22:16];
        step_s              = 1'b1;
        state_n             = ST_WAIT;
        cnt_n               = 4'd0;
      end

      ST_WAIT: begin
        if (cnt_r == WAIT_LAST) begin
          state_n = ST_CHECK;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt_r + 4'd1;
        end
      end

      ST_CHECK: begin
        if (mismatch_s) begin
          err_n = sat_inc16(err_r);
          if (!fail_seen_r) begin
            fail_seen_n = 1'b1;
            fail_vec_n  = io_r[C_LSB+6:A_LSB];
            fail_got_n  = dut_io_out[RES_W-1:0];
          end else begin
            fail_seen_n = fail_seen_r;
          end
        end else begin
          err_n = err_r;
        end
        if (vec_idx_r == LAST_IDX) begin
          state_n = ST_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == 16'd0);
        end else begin
          state_n   = ST_DRIVE;
          vec_idx_n = vec_idx_r + 23'd1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // All sequencer state and outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      vec_idx_r   <= 23'd0;
      io_r        <= IO_RESET;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_r       <= 16'd0;
      fail_vec_r  <= 23'd0;
      fail_got_r  <= 20'd0;
      fail_seen_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      vec_idx_r   <= vec_idx_n;
      io_r        <= io_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      pass_r      <= pass_n;
      err_r       <= err_n;
      fail_vec_r  <= fail_vec_n;
      fail_got_r  <= fail_got_n;
      fail_seen_r <= fail_seen_n;
    end
  end

  assign dut_io_in = io_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;
  assign fail_vec  = fail_vec_r;
  assign fail_got  = fail_got_r;

endmodule

// File: tb/tb_muladd_io_tester.sv
// tb_muladd_io_tester
// Four tester instances against bench-side MULADD design models:
//   u_a  N_VEC=4,   SAMPLE_DELAY=2, ideal design
//   u_b  N_VEC=300, SAMPLE_DELAY=3, ideal design, cycle-by-cycle model
//   u_c  N_VEC=400, SAMPLE_DELAY=2, io_out[5] stuck at 0
//   u_d  N_VEC=400, SAMPLE_DELAY=2, io_out[27:20] non-zero
module tb_muladd_io_tester;

  localparam int NA = 4,   SDA = 2;
  localparam int NB = 300, SDB = 3;
  localparam int NC = 400, SDC = 2;
  localparam int ND = 400, SDD = 2;
  localparam int ENDB = 2 + NB * (SDB + 1);
`ifdef MULADD_TESTER_LFSR_EN
  localparam logic [22:0] SEED_TB = 23'h000001;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
  logic [27:0] in_a, in_b, in_c, in_d;
  logic [27:0] out_a, out_b, out_c, out_d;
  logic busy_a, busy_b, busy_c, busy_d;
  logic done_a, done_b, done_c, done_d;
  logic pass_a, pass_b, pass_c, pass_d;
  logic [15:0] err_a, err_b, err_c, err_d;
  logic [22:0] fv_a, fv_b, fv_c, fv_d;
  logic [19:0] fg_a, fg_b, fg_c, fg_d;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // ---------------- reference functions ----------------
  function automatic logic [19:0] ref_abc(input logic [7:0] a, input logic [7:0] b, input logic [6:0] c);
    int sa, sb, p;
    logic [31:0] pv;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p  = sa * sb + int'(c);
    pv = p;
    return pv[19:0];
  endfunction

  function automatic logic [19:0] ref_w(input logic [22:0] w);
    return ref_abc(w[7:0], w[15:8], w[22:16]);
  endfunction

  function automatic logic [22:0] gen_word(input int k);
    logic [22:0] w;
`ifdef MULADD_TESTER_LFSR_EN
    w = SEED_TB;
    for (int i = 0; i < k; i++) w = {w[21:0], w[22] ^ w[17]};
`else
    w = 23'(k);
`endif
    return w;
  endfunction

  function automatic logic [27:0] pack_vec(input logic [22:0] w);
    return {3'b000, w, 1'b1, 1'b0};
  endfunction

  // Design model: one result register, held at zero while its reset pin is high
  function automatic logic [27:0] dut_resp(input logic [27:0] pins, input int mode);
    logic [27:0] r;
    r = 28'd0;
    if (!pins[0]) begin
      r[19:0] = ref_abc(pins[9:2], pins[17:10], pins[24:18]);
      if (mode == 1) r[5] = 1'b0;
      if (mode == 2) r[27:20] = 8'hA5;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    out_a <= dut_resp(in_a, 0);
    out_b <= dut_resp(in_b, 0);
    out_c <= dut_resp(in_c, 1);
    out_d <= dut_resp(in_d, 2);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- DUTs ----------------
  muladd_io_tester #(.N_VEC(NA), .SAMPLE_DELAY(SDA)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_io_in(in_a), .dut_io_out(out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_vec(fv_a), .fail_got(fg_a));
  muladd_io_tester #(.N_VEC(NB), .SAMPLE_DELAY(SDB)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_io_in(in_b), .dut_io_out(out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .fail_vec(fv_b), .fail_got(fg_b));
  muladd_io_tester #(.N_VEC(NC), .SAMPLE_DELAY(SDC)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .dut_io_in(in_c), .dut_io_out(out_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .fail_vec(fv_c), .fail_got(fg_c));
  muladd_io_tester #(.N_VEC(ND), .SAMPLE_DELAY(SDD)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .dut_io_in(in_d), .dut_io_out(out_d),
    .busy(busy_d), .done(done_d), .pass(pass_d), .err_count(err_d), .fail_vec(fv_d), .fail_got(fg_d));

  // ---------------- u_b run-timeline model ----------------
  // m_off = rising edges since the edge that accepted start
  logic m_run, m_done;
  int   m_off;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_off  <= 0;
    end else if (start_b && !m_run) begin
      m_run  <= 1'b1;
      m_done <= 1'b0;
      m_off  <= 0;
    end else if (m_run) begin
      m_off <= m_off + 1;
      if (m_off + 1 == ENDB) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
      end
    end
  end

  function automatic logic [27:0] exp_io_b(input logic run, input logic dn, input int off);
    if (run) begin
      if (off <= 2) return 28'h0000003;
      return pack_vec(gen_word((off - 3) / (SDB + 1)));
    end
    if (dn) return pack_vec(gen_word(NB - 1));
    return 28'h0000001;
  endfunction

  // Per-cycle compare of u_b against the timeline model
  always @(negedge clk) begin
    chk("b_io",   in_b,   exp_io_b(m_run, m_done, m_off));
    chk("b_busy", busy_b, m_run);
    chk("b_done", done_b, m_done);
    chk("b_pass", pass_b, m_done);
    chk("b_err",  err_b,  16'd0);
    chk("b_fvec", fv_b,   23'd0);
    chk("b_fgot", fg_b,   20'd0);
  end

  // ---------------- main sequence ----------------
  int cyc;
  int exp_err_c;
  logic [22:0] exp_fv_c, w_tmp;
  logic [19:0] exp_fg_c, r_tmp;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_io",   in_a,   28'h0000001);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_pass", pass_a, 1'b0);
    chk("rst_err",  err_a,  16'd0);
    chk("rst_fvec", fv_a,   23'd0);
    chk("rst_fgot", fg_a,   20'd0);
    rst_n = 1'b1;

    // Pin the reference arithmetic with hand-computed values
    chk("ref_3x5p1",   ref_abc(8'h03, 8'h05, 7'h01), 20'h00010);
    chk("ref_ffx2",    ref_abc(8'hFF, 8'h02, 7'h00), 20'hFFFFE);
    chk("ref_80x80p7f", ref_abc(8'h80, 8'h80, 7'h7F), 20'h0407F);

    // ---- u_a: run length, with a start pulse while busy ----
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    cyc = 1;
    chk("a_busy_after_start", busy_a, 1'b1);
    chk("a_io_dutrst", in_a, 28'h0000003);
    while (!done_a && cyc < 100) begin
      start_a = (cyc == 5);
      @(posedge clk); #1 start_a = 1'b0;
      cyc++;
    end
    chk("a_run_len", cyc, 15);
    chk("a_pass", pass_a, 1'b1);
    chk("a_err", err_a, 16'd0);
    chk("a_busy_end", busy_a, 1'b0);
    chk("a_io_last", in_a, pack_vec(gen_word(NA - 1)));
    chk("a_last_result", out_a[19:0], ref_w(gen_word(NA - 1)));

    // ---- u_a: start while DONE restarts ----
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    cyc = 1;
    chk("a_restart_done", done_a, 1'b0);
    chk("a_restart_busy", busy_a, 1'b1);
    while (!done_a && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("a_rerun_len", cyc, 15);
    chk("a_rerun_pass", pass_a, 1'b1);

    // ---- u_b: random start pulses while busy, reset in WAIT of vector 10 ----
    repeat ($urandom_range(1, 6)) @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    cyc = 1;
    while (!(m_run && m_off == 3 + 10 * (SDB + 1)) && cyc < 200) begin
      start_b = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1 start_b = 1'b0;
      cyc++;
    end
    chk("b_reach_vec10", cyc, 3 + 10 * (SDB + 1) + 1);
    chk("b_io_vec10", in_b, pack_vec(gen_word(10)));
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("b_midrst_io",   in_b,   28'h0000001);
    chk("b_midrst_busy", busy_b, 1'b0);
    chk("b_midrst_err",  err_b,  16'd0);
    rst_n = 1'b1;

    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    cyc = 1;
    chk("b_rerun_io0", in_b, 28'h0000003);
    while (!done_b && cyc < ENDB + 50) begin
      start_b = (m_off < ENDB - 5) && ($urandom_range(0, 15) == 0);
      @(posedge clk); #1 start_b = 1'b0;
      cyc++;
    end
    chk("b_run_len", cyc, ENDB + 1);
    chk("b_final_pass", pass_b, 1'b1);

    // ---- u_c / u_d: faulty designs ----
    exp_err_c = 0;
    exp_fv_c  = 23'd0;
    exp_fg_c  = 20'd0;
    for (int k = 0; k < NC; k++) begin
      w_tmp = gen_word(k);
      r_tmp = ref_w(w_tmp);
      if (r_tmp[5]) begin
        if (exp_err_c == 0) begin
          exp_fv_c = w_tmp;
          exp_fg_c = r_tmp & 20'hFFFDF;
        end
        exp_err_c++;
      end
    end

    @(posedge clk); #1;
    start_c = 1'b1;
    start_d = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    start_d = 1'b0;
    cyc = 1;
    while (!(done_c && done_d) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("c_run_len", cyc, 3 + NC * (SDC + 1));
    chk("c_err", err_c, 16'(exp_err_c));
    chk("c_pass", pass_c, (exp_err_c == 0) ? 1'b1 : 1'b0);
    chk("c_fvec", fv_c, exp_fv_c);
    chk("c_fgot", fg_c, exp_fg_c);
    chk("d_err", err_d, 16'(ND));
    chk("d_pass", pass_d, 1'b0);
    chk("d_done", done_d, 1'b1);
    chk("d_fvec", fv_d, gen_word(0));
    chk("d_fgot", fg_d, ref_w(gen_word(0)));

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muladd_io_tester.md
# muladd_io_tester

Self-checking stimulus/response engine for the 8x8+7 MULADD user design on the fabric IO ring. It drives the design's `io_in` pins (reset, enable, operands A/B/C), samples the registered 20-bit result returned on `io_out`, compares it against an internal reference model, and reports pass/fail with an error count and a first-failure capture. It sits on the far side of the user design's pin interface, either in a bench harness or in a companion test tile.

## Interface
- `N_VEC`, 256: vectors per run, 1..2^23.
- `SAMPLE_DELAY`, 2: cycles from driving a vector to sampling its result, 2..15.
- `SEED`, 23'h000001: LFSR seed; must be non-zero.
- `clk`  in  1  sole clock; the tester and the DUT share it.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a run; ignored while `busy`.
- `dut_io_in`  out  28  drives the DUT `io_in` pins.
- `dut_io_out`  in  28  DUT `io_out` pins.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  level; set at run end, cleared by the next accepted `start`.
- `pass`  out  1  equals `done && err_count==0`.
- `err_count`  out  16  mismatching vectors; saturates at 16'hFFFF.
- `fail_vec`  out  23  `{c,b,a}` of the first mismatch.
- `fail_got`  out  20  result observed at the first mismatch.

## Operation
- Pin map for `dut_io_in`:
  - [0] DUT reset, active high.
  - [1] enable, always 1 outside tester reset.
  - [9:2] a.
  - [17:10] b.
  - [24:18] c.
  - [27:25] 0.
- Result is taken from `dut_io_out[19:0]`. `dut_io_out[27:20]` must be 0; a non-zero value there also counts as a mismatch.
- Expected result: `sext20($signed(a)*$signed(b)) + zext20(c)`, modulo 2^20.
- State machine:
  - IDLE: `start` → DUT_RST.
  - DUT_RST: 2 cycles with bit0=1. On the second cycle, check `dut_io_out[19:0]==0`; a mismatch increments `err_count`. → DRIVE.
  - DRIVE: 1 cycle; register the next vector into `dut_io_in` with bit0=0. → WAIT.
  - WAIT: `SAMPLE_DELAY-1` cycles. → CHECK.
  - CHECK: 1 cycle. Compare, update `err_count`, capture the first failure. If `vec_idx==N_VEC-1` → DONE, else DRIVE.
  - DONE: hold outputs; `start` → DUT_RST.
- On an accepted `start`:
  - clear `err_count`, `fail_vec`, `fail_got`, `done`, `vec_idx`;
  - reload the operand generator.
- Operand generator produces a 23-bit word w, with a=w[7:0], b=w[15:8], c=w[22:16]. It advances once per DRIVE.

## Timing
- Reset values:
  - `dut_io_in`=28'h0000001 (DUT held in reset, enable low).
  - `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `fail_vec`=0, `fail_got`=0.
  - state IDLE.
- A vector driven at edge t is sampled at edge t+`SAMPLE_DELAY`. Each vector costs `SAMPLE_DELAY+1` cycles.
- Run length is 1 + 2 + `N_VEC`·(`SAMPLE_DELAY`+1) cycles from `start` to `done`.
- `start` in the same cycle as DONE is accepted. `start` during any other state is ignored.
- `rst_n` asserted mid-run immediately forces all reset values; no partial result is retained.
- `err_count` at 16'hFFFF stays there. `fail_*` are written only on the first mismatch of a run.

## Configuration
- `MULADD_TESTER_LFSR_EN` defined: w comes from a 23-bit Fibonacci LFSR (x^23+x^18+1), loaded with `SEED` on start.
- Undefined: w is an incrementing counter from 0, so vector k has a=k[7:0], b=k[15:8], c=k[22:16]. `N_VEC`=2^23 gives exhaustive coverage.

## Structure
- Package `muladd_tester_pkg` holds:
  - state enum;
  - pin-position localparams (RST_BIT, EN_BIT, A_LSB, B_LSB, C_LSB, RES_W=20);
  - function `muladd_expected(a,b,c)`.
- Sub-module `muladd_tester_opgen` contains the LFSR/counter selected by the macro, with `load`/`step` inputs and the 23-bit w output.

## Test plan
- Counter mode, `N_VEC`=4, ideal DUT model → vectors 0..3 give results 0,0,0,0; `done`=1, `pass`=1, run length 15 cycles.
- Single-vector checks:
  - a=8'h03, b=8'h05, c=7'h01 → expected 20'h00010.
  - a=8'hFF, b=8'h02, c=0 → 20'hFFFFE.
  - a=8'h80, b=8'h80, c=7'h7F → 20'h0407F; the model matches and no error is counted.
- DUT model with `io_out[5]` stuck at 0, LFSR mode, `N_VEC`=64 → `err_count`>0, `pass`=0, `fail_vec`/`fail_got` equal the first vector whose expected bit 5 is 1.
- `rst_n` pulsed low during WAIT of vector 10 → next cycle shows all reset values; a new `start` reruns from vector 0 with `err_count`=0.
- `start` pulsed while `busy` → ignored, run length unchanged. `start` while DONE → new run begins and `done` clears.
- DUT model returning non-zero `io_out[27:20]` → every CHECK counts an error; with `N_VEC` ≥ 65535 vectors, `err_count` saturates at 16'hFFFF.
